// File: rtl/scan_pkg.sv
// Shared definitions for the decoder scan sequencer.
//   state_t          : sequencer FSM states
//   SEL_FIRST/LAST   : first and last decoder select values of a frame
//   DWELL_W/BLANK_W  : widths of the dwell and blanking down-counters
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam logic [1:0] SEL_FIRST = 2'b00;
   localparam logic [1:0] SEL_LAST  = 2'b11;

   localparam int unsigned DWELL_W = 16;
   localparam int unsigned BLANK_W = 8;

endpackage

// File: rtl/scan_down_counter.sv
// Loadable down-counter with zero flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (highest priority)
//   load       : load load_val (beats dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at 0
//   count      : current value
//   zero       : count == 0
module scan_down_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer feeding a 2x4 decoder with enable. Steps {A,B} through 00..11, blanking
// (enable low) for BLANK_CYC cycles and then driving (enable high) for DIV cycles per select.
// Optional feature macro: SCAN_HOLD_EN adds a 'hold' input that freezes the sequencer.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : pulse, begins a scan when idle
//   stop           : pulse, aborts the scan (wins over start and hold)
//   one_shot       : level, latched on accepted start (1 = single frame)
//   hold           : (SCAN_HOLD_EN only) freeze state, select, counters and enable
//   A, B           : decoder select MSB/LSB
//   enable         : decoder enable
//   busy           : state is not IDLE
//   frame_done     : one-cycle pulse after the DRIVE of select 11 completes
module decoder_scan_ctrl
   import scan_pkg::*;
#(
   parameter int unsigned DIV       = 4,
   parameter int unsigned BLANK_CYC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic stop,
   input  logic one_shot,
`ifdef SCAN_HOLD_EN
   input  logic hold,
`endif
   output logic A,
   output logic B,
   output logic enable,
   output logic busy,
   output logic frame_done
);

   // Counters are loaded with N-1 so that a segment lasts exactly N cycles.
   localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(DIV - 1);
   localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
   // Segment entered after start or after a non-final dwell.
   localparam state_t SEG_STATE = (BLANK_CYC == 0) ? DRIVE : BLANK;

   state_t     state;
   logic [1:0] sel;
   logic       one_shot_q;
   logic       frozen;

   logic                dwell_load, dwell_dec, dwell_zero;
   logic                blank_load, blank_dec, blank_zero;
   logic [DWELL_W-1:0]  dwell_count;
   logic [BLANK_W-1:0]  blank_count;

`ifdef SCAN_HOLD_EN
   assign frozen = hold;
`else
   assign frozen = 1'b0;
`endif

   // Counter control decoded from the current state.
   always_comb begin
      dwell_load = 1'b0;
      dwell_dec  = 1'b0;
      blank_load = 1'b0;
      blank_dec  = 1'b0;
      if (!stop && !frozen) begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  dwell_load = (SEG_STATE == DRIVE);
                  blank_load = (SEG_STATE == BLANK);
               end
            end
            BLANK: begin
               if (blank_zero) dwell_load = 1'b1;
               else            blank_dec  = 1'b1;
            end
            DRIVE: begin
               if (dwell_zero) begin
                  if (!((sel == SEL_LAST) && one_shot_q)) begin
                     dwell_load = (SEG_STATE == DRIVE);
                     blank_load = (SEG_STATE == BLANK);
                  end
               end else begin
                  dwell_dec = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   scan_down_counter #(
      .WIDTH (DWELL_W)
   ) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (stop),
      .load     (dwell_load),
      .load_val (DWELL_INIT),
      .dec      (dwell_dec),
      .count    (dwell_count),
      .zero     (dwell_zero)
   );

   scan_down_counter #(
      .WIDTH (BLANK_W)
   ) u_blank (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (stop),
      .load     (blank_load),
      .load_val (BLANK_INIT),
      .dec      (blank_dec),
      .count    (blank_count),
      .zero     (blank_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= SEL_FIRST;
         one_shot_q <= 1'b0;
         enable     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (stop) begin
            state  <= IDLE;
            sel    <= SEL_FIRST;
            enable <= 1'b0;
         end else if (!frozen) begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     sel        <= SEL_FIRST;
                     one_shot_q <= one_shot;
                     state      <= SEG_STATE;
                     enable     <= (SEG_STATE == DRIVE);
                  end
               end
               BLANK: begin
                  if (blank_zero) begin
                     state  <= DRIVE;
                     enable <= 1'b1;
                  end
               end
               DRIVE: begin
                  if (dwell_zero) begin
                     if (sel == SEL_LAST) begin
                        frame_done <= 1'b1;
                        sel        <= SEL_FIRST;
                        if (one_shot_q) begin
                           state  <= IDLE;
                           enable <= 1'b0;
                        end else begin
                           state  <= SEG_STATE;
                           enable <= (SEG_STATE == DRIVE);
                        end
                     end else begin
                        sel    <= sel + 2'd1;
                        state  <= SEG_STATE;
                        enable <= (SEG_STATE == DRIVE);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign A    = sel[1];
   assign B    = sel[0];
   assign busy = (state != IDLE);

endmodule
